dmem_ctrl: RTL

Parametrised big-endian, byte-addressable data memory for the pipelined MIPS core, replacing the fixed 128-byte data memory in the MEM stage. It uses the same 4-bit MemOp encoding and adds a valid/ready request channel, a registered response with backpressure, and alignment/range error reporting. It also adds a post-reset clear sequence and architecturally correct big-endian swl/swr lane selection.

---
 rtl/dmem_pkg.sv | 26 ++
 rtl/dmem_lane_map.sv | 54 +++++
 rtl/dmem_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared MemOp codes, controller state and op helpers for the MEM-stage data memory.
package dmem_pkg;

  localparam logic [3:0] OP_SW  = 4'b0000;
  localparam logic [3:0] OP_SWR = 4'b0001;
  localparam logic [3:0] OP_LW  = 4'b0010;
  localparam logic [3:0] OP_LWL = 4'b0011;
  localparam logic [3:0] OP_SWL = 4'b0100;
  localparam logic [3:0] OP_LWR = 4'b0101;
  localparam logic [3:0] OP_LB  = 4'b0110;
  localparam logic [3:0] OP_LBU = 4'b0111;
  localparam logic [3:0] OP_LH  = 4'b1000;
  localparam logic [3:0] OP_LHU = 4'b1001;
  localparam logic [3:0] OP_SB  = 4'b1010;
  localparam logic [3:0] OP_SH  = 4'b1011;

  localparam int NUM_LANES = 4;

  typedef enum logic {INIT, RUN} state_e;

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SWR) || (op == OP_SWL) ||
           (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/dmem_lane_map.sv
// Big-endian lane steering: byte-write mask / shifted store data, alignment check,
// and load extract/extend. wmask[i] and data bits [8i+7:8i] belong to byte offset 3-i.
module dmem_lane_map
  import dmem_pkg::*;
(
  input  logic [3:0]           op,
  input  logic [1:0]           off,
  input  logic [31:0]          wdata,
  input  logic [31:0]          rword,
  output logic [NUM_LANES-1:0] wmask,
  output logic [31:0]          wdata_sh,
  output logic                 misalign,
  output logic                 op_bad,
  output logic [31:0]          rdata
);

  logic [31:0] rsh_b, rsh_h;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  // ~off == 3-off: distance of the addressed byte from the LSB lane
  assign rsh_b = rword >> {~off, 3'b000};
  assign rsh_h = rword >> {~off[1], 4'b0000};
  assign rbyte = rsh_b[7:0];
  assign rhalf = rsh_h[15:0];

  always_comb begin
    wmask    = '0;
    wdata_sh = '0;
    misalign = 1'b0;
    op_bad   = 1'b0;
    rdata    = '0;
    case (op)
      OP_SW:  begin wmask = 4'hF; wdata_sh = wdata; misalign = |off; end
      OP_SH:  begin
        wmask    = 4'b0011 << {~off[1], 1'b0};
        wdata_sh = wdata << {~off[1], 4'b0000};
        misalign = off[0];
      end
      OP_SB:  begin wmask = 4'b0001 << ~off; wdata_sh = {4{wdata[7:0]}}; end
      // swl fills a..(a|3) from the MSB of wdata; swr fills (a&~3)..a ending at wdata[7:0]
      OP_SWL: begin wmask = 4'hF >> off;  wdata_sh = wdata >> {off, 3'b000}; end
      OP_SWR: begin wmask = 4'hF << ~off; wdata_sh = wdata << {~off, 3'b000}; end
      OP_LW:  begin rdata = rword; misalign = |off; end
      OP_LWL, OP_LWR: rdata = rword;
      OP_LB:  rdata = {{24{rbyte[7]}}, rbyte};
      OP_LBU: rdata = {24'h0, rbyte};
      OP_LH:  begin rdata = {{16{rhalf[15]}}, rhalf}; misalign = off[0]; end
      OP_LHU: begin rdata = {16'h0, rhalf}; misalign = off[0]; end
      default: op_bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressable big-endian data memory with valid/ready request channel,
// one-deep registered response, error reporting and optional post-reset clear.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 128,
  parameter int AW          = 32,
  parameter int INIT_CLEAR  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [3:0]    req_op,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err
);

  localparam int WORDS = DEPTH_BYTES / 4;
  localparam int WAW   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int ABITS = $clog2(DEPTH_BYTES);

  state_e         state_q, state_d;
  logic [WAW-1:0] clr_q, clr_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [31:0]    rsp_rdata_q, rsp_rdata_d;
  logic           rsp_err_q, rsp_err_d;

  logic [WAW-1:0]                 widx, mem_idx;
  logic [31:0]                    rword, ld_data, wdata_sh;
  logic [NUM_LANES-1:0]           wmask, lane_we;
  logic [NUM_LANES-1:0][7:0]      lane_wd;
  logic                           misalign, op_bad, range_err, dir_err, err, accept, store;

  assign widx = req_addr[ABITS-1:2];

  dmem_lane_map u_lane_map (
    .op       (req_op),
    .off      (req_addr[1:0]),
    .wdata    (req_wdata),
    .rword    (rword),
    .wmask    (wmask),
    .wdata_sh (wdata_sh),
    .misalign (misalign),
    .op_bad   (op_bad),
    .rdata    (ld_data)
  );

  assign store     = is_store(req_op);
  assign range_err = req_addr >= AW'(DEPTH_BYTES);
  // a load code flagged as a write (or vice versa) is treated as a malformed request
  assign dir_err   = req_write != store;
  assign err       = misalign | op_bad | range_err | dir_err;
  assign req_ready = rst_n && (state_q == RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  always_comb begin
    if (state_q == INIT) begin
      lane_we = '1;
      mem_idx = clr_q;
      lane_wd = '0;
    end else begin
      lane_we = (accept && store && !err) ? wmask : '0;
      mem_idx = widx;
      lane_wd = wdata_sh;
    end
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [7:0] mem_q [WORDS];
    always_ff @(posedge clk) begin
      if (lane_we[l]) mem_q[mem_idx] <= lane_wd[l];
    end
    assign rword[8*l +: 8] = mem_q[widx];
  end

  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      INIT: begin
        clr_d = clr_q + 1'b1;
        if (clr_q == WAW'(WORDS - 1)) state_d = RUN;
      end
      default: ;
    endcase
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = err;
      rsp_rdata_d = (err || store) ? 32'h0 : ld_data;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_CLEAR != 0) state_q <= INIT;
      else                 state_q <= RUN;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
